// File: rtl/cpu_pkg.sv
// Shared types and constants for the CPU instruction store and its loader.
package cpu_pkg;

    localparam int ADDR_W = 3;
    localparam int DATA_W = 4;
    localparam int DEPTH  = 8;

    localparam logic [DATA_W-1:0] NOP_INSTR = 4'b0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CSUM = 2'd2,
        RUN  = 2'd3
    } state_t;

    // Running XOR checksum over the loaded program words.
    function automatic logic [DATA_W-1:0] csum_fold(input logic [DATA_W-1:0] acc,
                                                    input logic [DATA_W-1:0] word);
        return acc ^ word;
    endfunction

endpackage

// File: rtl/prog_ram.sv
// Instruction RAM: one synchronous write port, one asynchronous read port.
module prog_ram #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 4,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_r [DEPTH];

    // Write port; contents are not reset, readers gate by committed length.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/prog_loader.sv
// Program loader: streams nibbles into the instruction RAM and holds the CPU in reset meanwhile.
// Optional trailing checksum word is enabled by defining PROG_CHECKSUM_EN.
module prog_loader
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              rstn,
    input  logic              load_start,
    input  logic              load_abort,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    output logic              load_done,
    output logic              load_err,
    output logic [ADDR_W:0]   prog_len,
    input  logic [ADDR_W-1:0] pc_in,
    output logic [DATA_W-1:0] instr_out,
    output logic              cpu_rstn
);

    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   LEN_ONE  = (ADDR_W + 1)'(1);

    state_t            state_r;
    logic [ADDR_W-1:0] wr_ptr_r;
    logic [ADDR_W:0]   prog_len_r;
    logic              load_ready_r;
    logic              load_done_r;
    logic              load_err_r;
    logic              cpu_rstn_r;
`ifdef PROG_CHECKSUM_EN
    logic [DATA_W-1:0] csum_r;
    logic [ADDR_W:0]   len_pend_r;
`endif

    logic              hs_s;
    logic              term_s;
    logic              wr_en_s;
    logic [DATA_W-1:0] rd_data_s;

    assign hs_s   = load_valid && load_ready_r;
    assign term_s = load_last || (wr_ptr_r == PTR_LAST);

    // Abort and restart take priority over a coincident handshake.
    always_comb begin
        wr_en_s = 1'b0;
        if ((state_r == LOAD) && hs_s && !load_abort && !load_start) begin
            wr_en_s = 1'b1;
        end else begin
            wr_en_s = 1'b0;
        end
    end

    prog_ram #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram (
        .clk   (clk),
        .we    (wr_en_s),
        .waddr (wr_ptr_r),
        .wdata (load_data),
        .raddr (pc_in),
        .rdata (rd_data_s)
    );

    // Loader FSM with registered handshake, status and CPU-reset outputs.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_r      <= IDLE;
            wr_ptr_r     <= '0;
            prog_len_r   <= '0;
            load_ready_r <= 1'b0;
            load_done_r  <= 1'b0;
            load_err_r   <= 1'b0;
            cpu_rstn_r   <= 1'b0;
`ifdef PROG_CHECKSUM_EN
            csum_r       <= '0;
            len_pend_r   <= '0;
`endif
        end else begin
            load_done_r <= 1'b0;
            load_err_r  <= 1'b0;
            case (state_r)
                IDLE, RUN: begin
                    if (load_start) begin
                        state_r      <= LOAD;
                        wr_ptr_r     <= '0;
                        prog_len_r   <= '0;
                        load_ready_r <= 1'b1;
                        cpu_rstn_r   <= 1'b0;
`ifdef PROG_CHECKSUM_EN
                        csum_r       <= '0;
`endif
                    end
                end
                LOAD: begin
                    if (load_abort) begin
                        state_r      <= IDLE;
                        prog_len_r   <= '0;
                        load_ready_r <= 1'b0;
                    end else if (load_start) begin
                        wr_ptr_r     <= '0;
`ifdef PROG_CHECKSUM_EN
                        csum_r       <= '0;
`endif
                    end else if (hs_s) begin
                        wr_ptr_r <= wr_ptr_r + PTR_ONE;
                        if (term_s) begin
`ifdef PROG_CHECKSUM_EN
                            state_r    <= CSUM;
                            csum_r     <= csum_fold(csum_r, load_data);
                            len_pend_r <= {1'b0, wr_ptr_r} + LEN_ONE;
`else
                            state_r      <= RUN;
                            prog_len_r   <= {1'b0, wr_ptr_r} + LEN_ONE;
                            load_done_r  <= 1'b1;
                            load_ready_r <= 1'b0;
                            cpu_rstn_r   <= 1'b1;
`endif
                        end else begin
`ifdef PROG_CHECKSUM_EN
                            csum_r <= csum_fold(csum_r, load_data);
`endif
                        end
                    end
                end
                CSUM: begin
`ifdef PROG_CHECKSUM_EN
                    if (load_abort) begin
                        state_r      <= IDLE;
                        prog_len_r   <= '0;
                        load_ready_r <= 1'b0;
                    end else if (load_start) begin
                        state_r  <= LOAD;
                        wr_ptr_r <= '0;
                        csum_r   <= '0;
                    end else if (hs_s) begin
                        load_ready_r <= 1'b0;
                        if (load_data == csum_r) begin
                            state_r     <= RUN;
                            prog_len_r  <= len_pend_r;
                            load_done_r <= 1'b1;
                            cpu_rstn_r  <= 1'b1;
                        end else begin
                            state_r    <= IDLE;
                            prog_len_r <= '0;
                            load_err_r <= 1'b1;
                        end
                    end
`else
                    state_r      <= IDLE;
                    load_ready_r <= 1'b0;
`endif
                end
                default: begin
                    state_r      <= IDLE;
                    load_ready_r <= 1'b0;
                    cpu_rstn_r   <= 1'b0;
                end
            endcase
        end
    end

    assign load_ready = load_ready_r;
    assign load_done  = load_done_r;
    assign load_err   = load_err_r;
    assign prog_len   = prog_len_r;
    assign cpu_rstn   = cpu_rstn_r;
    assign instr_out  = ({1'b0, pc_in} < prog_len_r) ? rd_data_s : NOP_INSTR;

endmodule

// File: tb/tb_prog_loader.sv
// Directed self-checking bench for prog_loader (works with or without PROG_CHECKSUM_EN).
module tb_prog_loader;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       load_start = 1'b0;
    logic       load_abort = 1'b0;
    logic       load_valid = 1'b0;
    logic       load_ready;
    logic [3:0] load_data = 4'h0;
    logic       load_last = 1'b0;
    logic       load_done;
    logic       load_err;
    logic [3:0] prog_len;
    logic [2:0] pc_in = 3'd0;
    logic [3:0] instr_out;
    logic       cpu_rstn;

    int errors = 0;
    int checks = 0;

    logic [3:0] words8 [8] = '{4'h3, 4'hA, 4'h5, 4'hC, 4'h7, 4'hE, 4'h9, 4'h0};

    prog_loader dut (
        .clk        (clk),
        .rstn       (rstn),
        .load_start (load_start),
        .load_abort (load_abort),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .load_last  (load_last),
        .load_done  (load_done),
        .load_err   (load_err),
        .prog_len   (prog_len),
        .pc_in      (pc_in),
        .instr_out  (instr_out),
        .cpu_rstn   (cpu_rstn)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic read_check(input string tag, input logic [2:0] pc, input logic [3:0] exp);
        pc_in = pc;
        #1;
        check(tag, {4'h0, instr_out}, {4'h0, exp});
    endtask

    task automatic send_word(input logic [3:0] d, input logic last);
        load_valid = 1'b1;
        load_data  = d;
        load_last  = last;
        tick();
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    task automatic send_csum(input logic [3:0] c);
`ifdef PROG_CHECKSUM_EN
        send_word(c, 1'b0);
`else
        load_data = c;
`endif
    endtask

    task automatic pulse_start();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        rstn = 1'b1;
        check("rst_ready", {7'd0, load_ready}, 8'd0);
        check("rst_cpu_rstn", {7'd0, cpu_rstn}, 8'd0);
        check("rst_prog_len", {4'd0, prog_len}, 8'd0);
        check("rst_done", {7'd0, load_done}, 8'd0);
        for (int i = 0; i < 8; i++) read_check("rst_nop", 3'(i), 4'b0000);

        // Three-word program with last
        pulse_start();
        check("load_ready_on", {7'd0, load_ready}, 8'd1);
        send_word(4'b0101, 1'b0);
        send_word(4'b0001, 1'b0);
        send_word(4'b0010, 1'b1);
        send_csum(4'b0110);
        check("p3_done", {7'd0, load_done}, 8'd1);
        check("p3_len", {4'd0, prog_len}, 8'd3);
        check("p3_cpu_rstn", {7'd0, cpu_rstn}, 8'd1);
        check("p3_ready_off", {7'd0, load_ready}, 8'd0);
        tick();
        check("p3_done_pulse", {7'd0, load_done}, 8'd0);
        read_check("p3_pc0", 3'd0, 4'b0101);
        read_check("p3_pc1", 3'd1, 4'b0001);
        read_check("p3_pc2", 3'd2, 4'b0010);
        read_check("p3_pc3", 3'd3, 4'b0000);

        // Full eight-word program, no last; extra words refused
        pulse_start();
        check("reload_cpu_rstn", {7'd0, cpu_rstn}, 8'd0);
        for (int i = 0; i < 8; i++) send_word(words8[i], 1'b0);
        send_csum(4'h0);
        check("p8_done", {7'd0, load_done}, 8'd1);
        load_valid = 1'b1;
        load_data  = 4'hF;
        tick();
        tick();
        check("p8_ready_off", {7'd0, load_ready}, 8'd0);
        check("p8_len", {4'd0, prog_len}, 8'd8);
        load_valid = 1'b0;
        read_check("p8_pc0", 3'd0, 4'h3);
        read_check("p8_pc6", 3'd6, 4'h9);
        read_check("p8_pc7", 3'd7, 4'h0);

        // Start from RUN drops cpu_rstn, then abort with a coincident word
        pulse_start();
        check("run_start_cpu_rstn", {7'd0, cpu_rstn}, 8'd0);
        check("run_start_len", {4'd0, prog_len}, 8'd0);
        send_word(4'b0110, 1'b0);
        load_abort = 1'b1;
        send_word(4'b1011, 1'b0);
        load_abort = 1'b0;
        check("abort_ready", {7'd0, load_ready}, 8'd0);
        check("abort_len", {4'd0, prog_len}, 8'd0);
        check("abort_cpu_rstn", {7'd0, cpu_rstn}, 8'd0);
        read_check("abort_pc1", 3'd1, 4'b0000);
        send_word(4'b1100, 1'b1);
        check("idle_ignores_valid", {4'd0, prog_len}, 8'd0);
        check("idle_no_done", {7'd0, load_done}, 8'd0);

        // Single-word reload
        pulse_start();
        send_word(4'b1111, 1'b1);
        send_csum(4'b1111);
        check("p1_done", {7'd0, load_done}, 8'd1);
        check("p1_len", {4'd0, prog_len}, 8'd1);
        read_check("p1_pc0", 3'd0, 4'b1111);
        read_check("p1_pc1", 3'd1, 4'b0000);
        check("p1_cpu_rstn", {7'd0, cpu_rstn}, 8'd1);

        // Restart inside LOAD rewinds the write pointer
        pulse_start();
        send_word(4'h2, 1'b0);
        send_word(4'h4, 1'b0);
        pulse_start();
        check("restart_ready", {7'd0, load_ready}, 8'd1);
        send_word(4'h6, 1'b1);
        send_csum(4'h6);
        check("restart_len", {4'd0, prog_len}, 8'd1);
        read_check("restart_pc0", 3'd0, 4'h6);

        // Reset in the middle of a load hides the partial program
        pulse_start();
        send_word(4'h7, 1'b0);
        send_word(4'h8, 1'b0);
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        check("midrst_len", {4'd0, prog_len}, 8'd0);
        check("midrst_ready", {7'd0, load_ready}, 8'd0);
        check("midrst_cpu_rstn", {7'd0, cpu_rstn}, 8'd0);
        read_check("midrst_pc0", 3'd0, 4'b0000);

`ifdef PROG_CHECKSUM_EN
        pulse_start();
        send_word(4'b0101, 1'b0);
        send_word(4'b0011, 1'b1);
        check("cs_wait_ready", {7'd0, load_ready}, 8'd1);
        check("cs_wait_no_done", {7'd0, load_done}, 8'd0);
        send_word(4'b0110, 1'b0);
        check("cs_ok_done", {7'd0, load_done}, 8'd1);
        check("cs_ok_len", {4'd0, prog_len}, 8'd2);
        check("cs_ok_err", {7'd0, load_err}, 8'd0);
        pulse_start();
        send_word(4'b0101, 1'b0);
        send_word(4'b0011, 1'b1);
        send_word(4'b0111, 1'b0);
        check("cs_bad_err", {7'd0, load_err}, 8'd1);
        check("cs_bad_done", {7'd0, load_done}, 8'd0);
        check("cs_bad_len", {4'd0, prog_len}, 8'd0);
        check("cs_bad_cpu_rstn", {7'd0, cpu_rstn}, 8'd0);
        tick();
        check("cs_bad_err_pulse", {7'd0, load_err}, 8'd0);
`else
        check("err_tied_low", {7'd0, load_err}, 8'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Writer side of the CPU's instruction store: accepts a program over a valid/ready nibble stream and writes it into an 8-entry x 4-bit instruction RAM.
- The CPU reads the RAM by PC through a combinational port.
- Holds the CPU in reset while loading; releases it once the program is committed.
- Sits between the host/test driver and the cpu core; replaces the fixed ROM contents.

Parameters:
DEPTH, 8, number of instruction words; must equal 2**ADDR_W
ADDR_W, 3, PC/address width; matches pc_out width
DATA_W, 4, instruction width; matches rom_out width
NOP_INSTR, 4'b0000, value returned for unloaded addresses

Ports:
clk  input  1  system clock, all state on rising edge
rstn  input  1  synchronous active-low reset
load_start  input  1  pulse: begin a new program load (IDLE or RUN)
load_abort  input  1  abandon the load in progress
load_valid  input  1  load_data is valid
load_ready  output  1  loader accepts a word this cycle
load_data  input  DATA_W  instruction nibble
load_last  input  1  marks the final word, qualified by valid&ready
load_done  output  1  one-cycle pulse on commit
load_err  output  1  one-cycle pulse on checksum failure (0 unless PROG_CHECKSUM_EN)
prog_len  output  ADDR_W+1  number of committed words, 0..DEPTH
pc_in  input  ADDR_W  CPU program counter
instr_out  output  DATA_W  instruction at pc_in
cpu_rstn  output  1  drives the CPU's rstn; high only in RUN

Behaviour:
- One clock, clk. Reset is synchronous, active-low, on rstn.
- Reset values: state=IDLE, wr_ptr=0, prog_len=0, load_ready=0, load_done=0, load_err=0, cpu_rstn=0. RAM contents are not cleared; reads are gated by prog_len instead.
- States:
  - IDLE: load_ready=0. load_start moves to LOAD and clears wr_ptr and prog_len. load_valid is ignored.
  - LOAD: load_ready=1 (registered; high from the first LOAD cycle).
    - Each valid&ready handshake writes mem[wr_ptr]=load_data and increments wr_ptr.
    - A handshake with load_last=1, or the write to wr_ptr==DEPTH-1, ends the load. Next state is RUN, prog_len=wr_ptr+1, and load_done pulses in the first RUN cycle.
    - Words after the DEPTH-th cannot be accepted, because the state has already left LOAD.
    - load_abort returns to IDLE with prog_len=0. If load_abort and a handshake fall in the same cycle, abort wins and the write is discarded.
    - load_start in LOAD restarts with wr_ptr=0.
  - RUN: cpu_rstn=1, so the CPU leaves reset one cycle after commit, with its PC at 0. load_start moves to LOAD; cpu_rstn drops at that same edge.
- Read port is combinational: instr_out = mem[pc_in] if pc_in < prog_len, else NOP_INSTR. This applies in every state.
- Write and read of the same address never coincide, because the CPU is held in reset during LOAD.
- rstn low mid-load: back to IDLE immediately; the partial program is invisible (prog_len=0).

Optional Feature:
- PROG_CHECKSUM_EN defined:
  - After the terminating word, LOAD enters a sub-state CSUM with load_ready=1 and accepts exactly one more nibble.
  - If it equals the XOR of all loaded words: commit to RUN with load_done.
  - Otherwise: return to IDLE, prog_len=0, load_err pulses for one cycle.
  - load_abort is honoured in CSUM.
- Not defined: no CSUM state; commit follows the terminating word directly; load_err is tied to 0.

Decomposition:
- Shared package cpu_pkg:
  - state enum (IDLE, LOAD, CSUM, RUN)
  - DATA_W and ADDR_W constants
  - NOP_INSTR
- Sub-module prog_ram: DEPTH x DATA_W memory with one synchronous write port and one asynchronous read port. Loader FSM, pointer and checksum logic stay in prog_loader.

Test Plan:
- Reset, then pc_in=0..7 -> instr_out=0000 everywhere; cpu_rstn=0; load_ready=0.
- load_start, then stream 0101,0001,0010 with last on the 3rd -> load_done the cycle after; prog_len=3; cpu_rstn=1; pc 0/1/2 -> 0101/0001/0010; pc 3 -> 0000.
- Stream 8 words with no load_last, then keep valid high -> commit after the 8th; prog_len=8; the 9th word is never accepted (load_ready=0).
- Mid-load load_abort asserted together with a valid word -> IDLE; prog_len=0; the word is not written; instr_out=0000.
- In RUN, load_start -> cpu_rstn falls the next cycle. Reload 1111 (last) -> prog_len=1; pc 0 -> 1111; pc 1 -> 0000.
- With PROG_CHECKSUM_EN: words 0101,0011 then checksum 0110 -> commit. Repeat with checksum 0111 -> load_err pulse; prog_len=0; cpu_rstn stays 0.
